// File: rtl/matrix_3x3_gen_if.sv
// Pixel-stream in / 3x3 window out bundle for matrix_3x3_gen.
// MATRIX_SOF_EN adds the matrix_sof first-window flag.
`timescale 1ns/1ps
interface matrix_3x3_gen_if #(
    parameter int DATA_W = 8
);
    // Stream: a pixel is accepted on every rising edge with pix_vld=1 (no back-pressure).
    // Window: matrix_vld is a one-cycle strobe; matrix_p* are stable until the next accepted pixel.
    logic              pix_vld;
    logic              pix_sof;
    logic [DATA_W-1:0] pix_data;
    logic [DATA_W-1:0] matrix_p11, matrix_p12, matrix_p13;
    logic [DATA_W-1:0] matrix_p21, matrix_p22, matrix_p23;
    logic [DATA_W-1:0] matrix_p31, matrix_p32, matrix_p33;
    logic              matrix_vld;
`ifdef MATRIX_SOF_EN
    logic              matrix_sof;
`endif

    modport master (
        output pix_vld, pix_sof, pix_data,
        input  matrix_p11, matrix_p12, matrix_p13,
        input  matrix_p21, matrix_p22, matrix_p23,
        input  matrix_p31, matrix_p32, matrix_p33,
        input  matrix_vld
`ifdef MATRIX_SOF_EN
        , input matrix_sof
`endif
    );

    modport slave (
        input  pix_vld, pix_sof, pix_data,
        output matrix_p11, matrix_p12, matrix_p13,
        output matrix_p21, matrix_p22, matrix_p23,
        output matrix_p31, matrix_p32, matrix_p33,
        output matrix_vld
`ifdef MATRIX_SOF_EN
        , output matrix_sof
`endif
    );
endinterface

// File: rtl/matrix_3x3_gen.sv
// Line-buffered 3x3 window generator for a row-major pixel stream.
// Optional macro MATRIX_SOF_EN: adds matrix_sof marking each frame's first window.
`timescale 1ns/1ps
module matrix_3x3_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_W     = 8
) (
    input  logic          clk,
    input  logic          rst,
    matrix_3x3_gen_if.slave win
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]     col_q, col_d, cur_col;
    logic [RW-1:0]     row_q, row_d, cur_row;
    logic [DATA_W-1:0] lb1_q [IMG_WIDTH];
    logic [DATA_W-1:0] lb2_q [IMG_WIDTH];
    logic [DATA_W-1:0] lb1_rd, lb2_rd;
    logic [DATA_W-1:0] win_q [3][3];
    logic              vld_q, vld_d;
    logic              accept, sof_hit;

    assign accept  = win.pix_vld;
    assign sof_hit = win.pix_vld & win.pix_sof;

    // A start-of-frame pixel is (0,0) whatever the counters hold.
    always_comb begin
        cur_col = sof_hit ? '0 : col_q;
        cur_row = sof_hit ? '0 : row_q;
        lb1_rd  = lb1_q[cur_col];
        lb2_rd  = lb2_q[cur_col];
        col_d   = col_q;
        row_d   = row_q;
        if (accept) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
        vld_d = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    end

    // Line buffers are never reset; matrix_vld hides whatever they held.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[cur_col] <= win.pix_data;
            lb2_q[cur_col] <= lb1_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            vld_q <= 1'b0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    win_q[i][j] <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            vld_q <= vld_d;
            if (accept) begin
                for (int i = 0; i < 3; i++) begin
                    win_q[i][0] <= win_q[i][1];
                    win_q[i][1] <= win_q[i][2];
                end
                win_q[0][2] <= lb2_rd;
                win_q[1][2] <= lb1_rd;
                win_q[2][2] <= win.pix_data;
            end
        end
    end

`ifdef MATRIX_SOF_EN
    logic sof_q, sof_d;
    assign sof_d = accept && (cur_row == RW'(2)) && (cur_col == CW'(2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sof_q <= 1'b0;
        else     sof_q <= sof_d;
    end

    assign win.matrix_sof = sof_q;
`endif

    assign win.matrix_p11 = win_q[0][0];
    assign win.matrix_p12 = win_q[0][1];
    assign win.matrix_p13 = win_q[0][2];
    assign win.matrix_p21 = win_q[1][0];
    assign win.matrix_p22 = win_q[1][1];
    assign win.matrix_p23 = win_q[1][2];
    assign win.matrix_p31 = win_q[2][0];
    assign win.matrix_p32 = win_q[2][1];
    assign win.matrix_p33 = win_q[2][2];
    assign win.matrix_vld = vld_q;
endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Self-checking bench for matrix_3x3_gen on a 4x4 image, pixel = base + row*16 + col.
`timescale 1ns/1ps
module tb_matrix_3x3_gen;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 8;
  localparam int EW = 9 * DW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  matrix_3x3_gen_if #(.DATA_W(DW)) win ();

  matrix_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .win (win)
  );

  always #5 clk = ~clk;

  logic [EW-1:0] exp_q[$];
  int n_checks  = 0;
  int n_pass    = 0;
  int n_strobes = 0;
  int n_sof     = 0;

  // Expected window for accepted pixel (r,c) of a frame with the given base; top bit is matrix_sof.
  function automatic logic [EW-1:0] exp_window(input logic [7:0] base, input int r, input int c);
    logic [EW-1:0] v;
    v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v[EW-2-(i*3+j)*DW -: DW] = base + 8'((r - 2 + i) * 16 + (c - 2 + j));
`ifdef MATRIX_SOF_EN
    v[EW-1] = (r == 2) && (c == 2);
`endif
    return v;
  endfunction

  function automatic logic [EW-1:0] obs_window();
    logic s;
    s = 1'b0;
`ifdef MATRIX_SOF_EN
    s = win.matrix_sof;
`endif
    return {s, win.matrix_p11, win.matrix_p12, win.matrix_p13,
               win.matrix_p21, win.matrix_p22, win.matrix_p23,
               win.matrix_p31, win.matrix_p32, win.matrix_p33};
  endfunction

  // Scoreboard consumer: every window strobe pops one expectation.
  always @(negedge clk) begin
    logic [EW-1:0] e, o;
    if (win.matrix_vld === 1'b1) begin
      n_strobes++;
`ifdef MATRIX_SOF_EN
      if (win.matrix_sof === 1'b1) n_sof++;
`endif
      n_checks++;
      o = obs_window();
      if (exp_q.size() == 0) begin
        $display("FAIL window_unexpected: got %h, required no strobe", o);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) $display("FAIL window: got %h, required %h", o, e);
        else n_pass++;
      end
    end
`ifdef MATRIX_SOF_EN
    else if (win.matrix_sof === 1'b1) begin
      n_checks++;
      $display("FAIL sof_without_vld: got matrix_sof=1, required 0");
    end
`endif
  end

  task automatic drive_pixel(input logic [7:0] base, input int r, input int c, input bit sof);
    win.pix_vld  = 1'b1;
    win.pix_sof  = sof;
    win.pix_data = base + 8'(r * 16 + c);
    if (r >= 2 && c >= 2) exp_q.push_back(exp_window(base, r, c));
    @(posedge clk);
    #1;
    win.pix_vld = 1'b0;
    win.pix_sof = 1'b0;
  endtask

  task automatic drive_frame(input logic [7:0] base);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        drive_pixel(base, r, c, (r == 0) && (c == 0));
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs_window() !== '0) $display("FAIL reset_window: got %h, required 0", obs_window());
    else n_pass++;
    n_checks++;
    if (win.matrix_vld !== 1'b0) $display("FAIL reset_vld: got %b, required 0", win.matrix_vld);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_continuous();
    int s0;
    s0 = n_strobes;
    drive_frame(8'h00);
    settle();
    n_checks++;
    if (n_strobes - s0 != 4) $display("FAIL cont_count: got %0d, required 4", n_strobes - s0);
    else n_pass++;
    n_checks++;
    if (win.matrix_p33 !== 8'h33 || win.matrix_p11 !== 8'h11)
      $display("FAIL cont_last: got p11=%h p33=%h, required 11/33", win.matrix_p11, win.matrix_p33);
    else n_pass++;
  endtask

  task automatic test_stall();
    int s0;
    s0 = n_strobes;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        drive_pixel(8'h00, r, c, (r == 0) && (c == 0));
        repeat (3) begin
          @(posedge clk);
          #1;
          n_checks++;
          if (win.matrix_vld !== 1'b0) $display("FAIL stall_vld: got %b at (%0d,%0d), required 0", win.matrix_vld, r, c);
          else n_pass++;
        end
      end
    n_checks++;
    if (n_strobes - s0 != 4) $display("FAIL stall_count: got %0d, required 4", n_strobes - s0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int s0, f0;
    s0 = n_strobes;
    f0 = n_sof;
    drive_frame(8'h00);
    drive_frame(8'h80);
    settle();
    n_checks++;
    if (n_strobes - s0 != 8) $display("FAIL b2b_count: got %0d, required 8", n_strobes - s0);
    else n_pass++;
`ifdef MATRIX_SOF_EN
    n_checks++;
    if (n_sof - f0 != 2) $display("FAIL b2b_sof_count: got %0d, required 2", n_sof - f0);
    else n_pass++;
`endif
  endtask

  task automatic test_sof_mid_frame();
    int s0;
    s0 = n_strobes;
    for (int c = 0; c < W; c++) drive_pixel(8'h00, 0, c, c == 0);
    for (int c = 0; c < 3; c++) drive_pixel(8'h00, 1, c, 1'b0);
    drive_frame(8'h40);
    settle();
    n_checks++;
    if (n_strobes - s0 != 4) $display("FAIL sofmid_count: got %0d, required 4", n_strobes - s0);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int s0;
    s0 = n_strobes;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W; c++) drive_pixel(8'h00, r, c, (r == 0) && (c == 0));
    drive_pixel(8'h00, 3, 0, 1'b0);
    drive_pixel(8'h00, 3, 1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs_window() !== '0 || win.matrix_vld !== 1'b0)
      $display("FAIL midrst_outputs: got %h vld=%b, required 0", obs_window(), win.matrix_vld);
    else n_pass++;
    n_checks++;
    if (n_strobes - s0 != 2 || exp_q.size() != 0)
      $display("FAIL midrst_pre: got %0d strobes %0d pending, required 2/0", n_strobes - s0, exp_q.size());
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    s0 = n_strobes;
    drive_frame(8'h60);
    settle();
    n_checks++;
    if (n_strobes - s0 != 4) $display("FAIL midrst_count: got %0d, required 4", n_strobes - s0);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    win.pix_vld  = 1'b0;
    win.pix_sof  = 1'b0;
    win.pix_data = '0;
    test_reset();
    test_continuous();
    test_stall();
    test_back_to_back();
    test_sof_mid_frame();
    test_mid_reset();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL pending_windows: got %0d, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
